// File: rtl/cpu_regfile_pkg.sv
// Shared types and constants for the CPU register file and its read unit.
package cpu_regfile_pkg;

  localparam int REG_DATA_W = 16;
  localparam int REG_NUM    = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // Output buffer occupancy of the read port.
  typedef enum logic [0:0] {
    RD_EMPTY = 1'b0,
    RD_FULL  = 1'b1
  } rd_buf_state_t;

endpackage

// File: rtl/reg_read_unit_if.sv
// Bus bundle for reg_read_unit: two write ports plus the read request/result port.
//
// Read handshake: a request is accepted on a rising edge where rd_Req && rd_Ready.
// The result appears with rd_Valid=1 after that edge and stays stable until an
// edge where rd_Ack=1. rd_Ready is high when the buffer is empty or is being
// acknowledged in the same cycle, so back-to-back transfers run at full rate.
interface reg_read_unit_if
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              wr_En0;
  logic [ADDR_W-1:0] wr_Addr0;
  logic [DATA_W-1:0] wr_Data0;
  logic              wr_En1;
  logic [ADDR_W-1:0] wr_Addr1;
  logic [DATA_W-1:0] wr_Data1;

  logic              rd_Req;
  logic [ADDR_W-1:0] rd_AddrA;
  logic [ADDR_W-1:0] rd_AddrB;
  logic              rd_Ready;
  logic              rd_Valid;
  logic [DATA_W-1:0] rd_DataA;
  logic [DATA_W-1:0] rd_DataB;
  logic              rd_Ack;

  // Producer/consumer side (CPU pipeline, testbench).
  modport master (
    output wr_En0, wr_Addr0, wr_Data0,
    output wr_En1, wr_Addr1, wr_Data1,
    output rd_Req, rd_AddrA, rd_AddrB, rd_Ack,
    input  rd_Ready, rd_Valid, rd_DataA, rd_DataB
  );

  // Register read unit side.
  modport slave (
    input  wr_En0, wr_Addr0, wr_Data0,
    input  wr_En1, wr_Addr1, wr_Data1,
    input  rd_Req, rd_AddrA, rd_AddrB, rd_Ack,
    output rd_Ready, rd_Valid, rd_DataA, rd_DataB
  );

endinterface

// File: rtl/reg_read_unit_bypass.sv
// reg_bypass_mux: combinational read of one register address with same-cycle
// bypass from the two write ports (port 1 wins). Write enables arrive already
// qualified (range / hardwired-zero), so a dropped write never bypasses.
module reg_bypass_mux
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic [DATA_W-1:0] bank_i [NUM_REGS],
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] wa0_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] wa1_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic in_range;

  // Only non-power-of-two banks can see an address with no register behind it.
  generate
    if (NUM_REGS >= (1 << ADDR_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = ({{(32-ADDR_W){1'b0}}, rd_addr_i} < 32'(NUM_REGS));
    end
  endgenerate

  // Newest value wins: port 1 write, then port 0 write, then stored contents.
  always_comb begin
    rd_data_o = '0;
    if (we1_i && (wa1_i == rd_addr_i)) begin
      rd_data_o = wd1_i;
    end else if (we0_i && (wa0_i == rd_addr_i)) begin
      rd_data_o = wd0_i;
    end else if (in_range) begin
      rd_data_o = bank_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/reg_read_unit.sv
// reg_read_unit: dual-write register bank with a dual-operand read port and a
// 1-deep snapshot output buffer (valid/ack handshake).
// Optional build macro: REG_READ_UNIT_ZERO_REG_EN makes register 0 read as zero
// and silently drops every write aimed at it.
module reg_read_unit
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic           Clk,
  input  logic           Rst,
  reg_read_unit_if.slave bus,
  output rd_buf_state_t  dbg_state_o
);

  logic [DATA_W-1:0] bank_q [NUM_REGS];
  rd_buf_state_t     state_q, state_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic [DATA_W-1:0] byp_a, byp_b;
  logic              wa0_in, wa1_in;
  logic              we0_ok, we1_ok;
  logic              rd_ready;
  logic              accept;

  // Writes to addresses with no backing register are dropped.
  generate
    if (NUM_REGS >= (1 << ADDR_W)) begin : g_full_range
      assign wa0_in = 1'b1;
      assign wa1_in = 1'b1;
    end else begin : g_part_range
      assign wa0_in = ({{(32-ADDR_W){1'b0}}, bus.wr_Addr0} < 32'(NUM_REGS));
      assign wa1_in = ({{(32-ADDR_W){1'b0}}, bus.wr_Addr1} < 32'(NUM_REGS));
    end
  endgenerate

`ifdef REG_READ_UNIT_ZERO_REG_EN
  assign we0_ok = bus.wr_En0 && wa0_in && (bus.wr_Addr0 != '0);
  assign we1_ok = bus.wr_En1 && wa1_in && (bus.wr_Addr1 != '0);
`else
  assign we0_ok = bus.wr_En0 && wa0_in;
  assign we1_ok = bus.wr_En1 && wa1_in;
`endif

  // Register bank update; port 1 overrides port 0 on an address collision.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we1_ok && (bus.wr_Addr1 == ADDR_W'(i))) begin
          bank_q[i] <= bus.wr_Data1;
        end else if (we0_ok && (bus.wr_Addr0 == ADDR_W'(i))) begin
          bank_q[i] <= bus.wr_Data0;
        end
      end
    end
  end

  reg_bypass_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_mux_a (
    .bank_i   (bank_q),
    .rd_addr_i(bus.rd_AddrA),
    .we0_i    (we0_ok),
    .wa0_i    (bus.wr_Addr0),
    .wd0_i    (bus.wr_Data0),
    .we1_i    (we1_ok),
    .wa1_i    (bus.wr_Addr1),
    .wd1_i    (bus.wr_Data1),
    .rd_data_o(byp_a)
  );

  reg_bypass_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_mux_b (
    .bank_i   (bank_q),
    .rd_addr_i(bus.rd_AddrB),
    .we0_i    (we0_ok),
    .wa0_i    (bus.wr_Addr0),
    .wd0_i    (bus.wr_Data0),
    .we1_i    (we1_ok),
    .wa1_i    (bus.wr_Addr1),
    .wd1_i    (bus.wr_Data1),
    .rd_data_o(byp_b)
  );

  assign rd_ready = (state_q == RD_EMPTY) || bus.rd_Ack;
  assign accept   = bus.rd_Req && rd_ready;

  // Buffer next state: load a snapshot on accept, drain on ack, else hold.
  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (accept) begin
      state_d  = RD_FULL;
      data_a_d = byp_a;
      data_b_d = byp_b;
    end else if (bus.rd_Ack) begin
      state_d  = RD_EMPTY;
    end
  end

  // Output buffer registers; data is kept after ack until the next accept.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= RD_EMPTY;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign bus.rd_Ready = rd_ready;
  assign bus.rd_Valid = (state_q == RD_FULL);
  assign bus.rd_DataA = data_a_q;
  assign bus.rd_DataB = data_b_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_reg_read_unit.sv
// Testbench for reg_read_unit: directed scenarios followed by random traffic,
// all checked against a register-array model of the unit's behaviour.
module tb_reg_read_unit;
  import cpu_regfile_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
`ifdef REG_READ_UNIT_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst;
  rd_buf_state_t dbg_state;

  reg_read_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_read_unit #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and the result the consumer should see.
  logic [DW-1:0] model_regs [NR];
  logic          exp_valid;
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit writable(input logic [AW-1:0] a);
    return (a != '0) || !ZERO_REG;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    exp_valid = 1'b0;
    exp_a     = '0;
    exp_b     = '0;
  endtask

  task automatic drive(input logic req, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic ack,
                       input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                       input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1);
    bus.rd_Req   = req;
    bus.rd_AddrA = a;
    bus.rd_AddrB = b;
    bus.rd_Ack   = ack;
    bus.wr_En0   = we0;
    bus.wr_Addr0 = wa0;
    bus.wr_Data0 = wd0;
    bus.wr_En1   = we1;
    bus.wr_Addr1 = wa1;
    bus.wr_Data1 = wd1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " valid"}, 32'(bus.rd_Valid), 32'(exp_valid));
    check({tag, " dataA"}, 32'(bus.rd_DataA), 32'(exp_a));
    check({tag, " dataB"}, 32'(bus.rd_DataB), 32'(exp_b));
    check({tag, " state"}, 32'(dbg_state), 32'(exp_valid ? RD_FULL : RD_EMPTY));
  endtask

  // One clock with the currently driven inputs: check ready, advance model, check outputs.
  task automatic cycle(input string tag);
    logic [DW-1:0] nxt [NR];
    bit            ready_exp;
    #1;
    ready_exp = !exp_valid || bus.rd_Ack;
    check({tag, " ready"}, 32'(bus.rd_Ready), 32'(ready_exp));
    nxt = model_regs;
    if (bus.wr_En0 && writable(bus.wr_Addr0)) nxt[bus.wr_Addr0] = bus.wr_Data0;
    if (bus.wr_En1 && writable(bus.wr_Addr1)) nxt[bus.wr_Addr1] = bus.wr_Data1;
    if (bus.rd_Req && ready_exp) begin
      exp_a     = nxt[bus.rd_AddrA];
      exp_b     = nxt[bus.rd_AddrB];
      exp_valid = 1'b1;
    end else if (bus.rd_Ack) begin
      exp_valid = 1'b0;
    end
    model_regs = nxt;
    @(posedge Clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      drive(1'b1, AW'(i), AW'(NR - 1 - i), 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
      cycle(tag);
    end
    idle();
    bus.rd_Ack = 1'b1;
    cycle(tag);
    idle();
  endtask

  initial begin
    // Reset
    Rst = 1'b1;
    idle();
    model_reset();
    #3;
    check_outputs("reset");
    check("reset ready", 32'(bus.rd_Ready), 32'd1);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Read of fresh registers A=3, B=5
    drive(1'b1, 3'd3, 3'd5, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("rd_fresh");
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_fresh");
    idle();

    // Port 0 write then read
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, '0, '0);
    cycle("wr_r3");
    drive(1'b1, 3'd3, 3'd3, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("rd_r3");
    check("rd_r3 literal", 32'(bus.rd_DataA), 32'h1234);
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_r3");

    // Same-edge collision with bypass on the read
    drive(1'b1, 3'd2, 3'd2, 1'b0, 1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    cycle("collide");
    check("collide literal", 32'(bus.rd_DataA), 32'h5555);
    drive(1'b1, 3'd2, 3'd3, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("reread_r2");
    check("reread_r2 literal", 32'(bus.rd_DataA), 32'h5555);
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_r2");

    // Snapshot hold while not acknowledged
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 3'd4, 16'h0001);
    cycle("wr_r4");
    drive(1'b1, 3'd4, 3'd4, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("rd_r4");
    drive(1'b1, 3'd1, 3'd1, 1'b0, 1'b1, 3'd4, 16'hBEEF, 1'b0, '0, '0);
    cycle("hold1");
    check("hold literal", 32'(bus.rd_DataA), 32'h0001);
    drive(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("hold2");
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_r4");
    drive(1'b1, 3'd4, 3'd0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("rd_r4_new");
    check("rd_r4_new literal", 32'(bus.rd_DataA), 32'hBEEF);
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_r4_new");

    // Back-to-back full throughput, addresses 0..3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), AW'(i + 4), 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
      cycle("b2b");
    end
    idle();
    bus.rd_Ack = 1'b1;
    cycle("b2b_drain");

    // Ack while empty is ignored
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_empty");

    // Reset while holding a result
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd1, 16'h00FF, 1'b0, '0, '0);
    cycle("wr_r1");
    drive(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("rd_r1");
    idle();
    Rst = 1'b1;
    model_reset();
    #1;
    check_outputs("mid_reset");
    check("mid_reset ready", 32'(bus.rd_Ready), 32'd1);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    read_all("post_reset");

    // Register 0 behaviour (ordinary or hardwired zero depending on build)
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, '0, '0);
    cycle("wr_r0");
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 16'h7777);
    cycle("rd_r0_bypass");
    idle();
    bus.rd_Ack = 1'b1;
    cycle("ack_r0");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NR - 1)),
            AW'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom));
      cycle("rand");
    end
    idle();
    bus.rd_Ack = 1'b1;
    cycle("rand_drain");
    read_all("final_bank");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
